// File: rtl/xvga_scan_engine.sv
// XVGA (1024x768 @ 60 Hz) raster timing and pin driver.
// Produces the hcount/vcount raster for the renderers, then takes their merged
// pixel back PIX_LATENCY clocks later. Syncs and blank are delayed by the same
// amount so colour and sync reach the connector together.
module xvga_scan_engine #(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_BP        = 160,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 29,
  parameter int unsigned PIX_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        blank_out,
  output logic        frame_start_out,
  output logic [15:0] frame_count_out,
  input  logic [11:0] pixel_in,
  output logic [3:0]  vga_r_out,
  output logic [3:0]  vga_g_out,
  output logic [3:0]  vga_b_out,
  output logic        vga_hs_out,
  output logic        vga_vs_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bad geometry or latency must stop elaboration rather than silently wrap.
  if (PIX_LATENCY > 7) begin : g_bad_latency
    $error("xvga_scan_engine: PIX_LATENCY must be in 0..7");
  end
  if (H_TOTAL > 2048 || H_TOTAL == 0) begin : g_bad_htotal
    $error("xvga_scan_engine: H_TOTAL must fit in 11 bits");
  end
  if (V_TOTAL > 1024 || V_TOTAL == 0) begin : g_bad_vtotal
    $error("xvga_scan_engine: V_TOTAL must fit in 10 bits");
  end

  // Decode boundaries are one bit wider than the counters so an edge equal to
  // the full 11/10-bit range still compares correctly.
  localparam logic [10:0] HLast       = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VLast       = 10'(V_TOTAL - 1);
  localparam logic [11:0] HActiveEnd  = 12'(H_ACTIVE);
  localparam logic [11:0] HSyncStart  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActiveEnd  = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncStart  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        blank_q, blank_d;
  logic        hs_raw_q, hs_raw_d;
  logic        vs_raw_q, vs_raw_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Raster advance and raw timing decode from the next-state counters, so the
  // registered sync/blank line up with the registered coordinates.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == HLast) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 10'd1;
    end

    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    frame_count_d = frame_count_q + {15'd0, frame_start_d};

    blank_d  = ({1'b0, hcount_d} >= HActiveEnd) || ({1'b0, vcount_d} >= VActiveEnd);
    hs_raw_d = !(({1'b0, hcount_d} >= HSyncStart) && ({1'b0, hcount_d} < HSyncEnd));
    vs_raw_d = !(({1'b0, vcount_d} >= VSyncStart) && ({1'b0, vcount_d} < VSyncEnd));
  end

  // Raster state; reset parks on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_q      <= HLast;
      vcount_q      <= VLast;
      blank_q       <= 1'b1;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      blank_q       <= blank_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Delay line bundle order: {blank, hs, vs}. Idle value is all ones.
  logic [2:0] raw_bundle;
  logic [2:0] dly_bundle;

  assign raw_bundle = {blank_q, hs_raw_q, vs_raw_q};

  if (PIX_LATENCY == 0) begin : g_no_delay
    assign dly_bundle = raw_bundle;
  end else begin : g_delay
    logic [2:0] dly_q [PIX_LATENCY];
    logic [2:0] dly_d [PIX_LATENCY];

    // Shift the timing bundle one stage per clock.
    always_comb begin
      dly_d[0] = raw_bundle;
      for (int i = 1; i < int'(PIX_LATENCY); i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end

    // Delay stages reset to blanked, syncs inactive.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        for (int i = 0; i < int'(PIX_LATENCY); i++) begin
          dly_q[i] <= 3'b111;
        end
      end else begin
        for (int i = 0; i < int'(PIX_LATENCY); i++) begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    assign dly_bundle = dly_q[PIX_LATENCY-1];
  end

  logic        dly_blank, dly_hs, dly_vs;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  assign {dly_blank, dly_hs, dly_vs} = dly_bundle;

  // Output stage: pixel is forced black whenever the aligned blank is set.
  always_comb begin
    rgb_d = dly_blank ? 12'h000 : pixel_in;
    hs_d  = dly_hs;
    vs_d  = dly_vs;
  end

  // Pin registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign blank_out       = blank_q;
  assign frame_start_out = frame_start_q;
  assign frame_count_out = frame_count_q;
  assign vga_r_out       = rgb_q[11:8];
  assign vga_g_out       = rgb_q[7:4];
  assign vga_b_out       = rgb_q[3:0];
  assign vga_hs_out      = hs_q;
  assign vga_vs_out      = vs_q;

endmodule

// File: doc/xvga_scan_engine.md
Name: xvga_scan_engine

Overview:
- Display-side timing and output engine for the 1024x768 @ 60 Hz XVGA screen.
- Generates the hcount/vcount raster coordinates consumed by every sprite and table/counter renderer.
- Takes back the merged 12-bit pixel those renderers produce, and drives the VGA pins.
- Delays hsync, vsync and blank so they line up with the renderer pipeline latency, giving pixel-exact alignment at the connector.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync pulse width (clocks)
- H_BP, 160, horizontal back porch; H_TOTAL = 1344
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch; V_TOTAL = 806
- PIX_LATENCY, 2, clocks from hcount_out/vcount_out to the matching valid pixel_in; legal range 0..7

Ports:
- clk_in  input  1  65 MHz pixel clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- hcount_out  output  11  current pixel column, 0..H_TOTAL-1
- vcount_out  output  10  current line, 0..V_TOTAL-1
- blank_out  output  1  high when hcount_out >= H_ACTIVE or vcount_out >= V_ACTIVE
- frame_start_out  output  1  one-clock pulse while counters are (0,0)
- frame_count_out  output  16  frames started since reset
- pixel_in  input  12  RGB444 pixel for coordinates presented PIX_LATENCY clocks earlier
- vga_r_out, vga_g_out, vga_b_out  output  4 each  pin colour
- vga_hs_out, vga_vs_out  output  1 each  pin syncs, active-low

Behaviour:
- All outputs are registered.
- Reset is asynchronous and active-low, and takes effect immediately with no clock edge.
- Reset values:
  - hcount_out = H_TOTAL-1, vcount_out = V_TOTAL-1
  - blank_out = 1, frame_start_out = 0, frame_count_out = 0
  - rgb = 0, hs = vs = 1
  - every delay-line stage: blank = 1, hs = vs = 1
- Counters:
  - hcount_out increments every clock and wraps from H_TOTAL-1 to 0.
  - On that wrap, vcount_out increments, wrapping from V_TOTAL-1 to 0.
  - First edge after reset release therefore lands on (0,0).
- Frame start:
  - frame_start_out is 1 exactly during the clock in which the counters read (0,0), including the first frame after reset.
  - frame_count_out increments (mod 2^16) on the same edge that sets frame_start_out.
- Raw sync and blank (decoded from next-state counter values, so they are cycle-aligned with hcount_out/vcount_out):
  - hs_raw = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183).
  - vs_raw = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776), for the whole line.
  - blank_raw drives blank_out directly.
- Alignment:
  - hs_raw, vs_raw and blank_raw pass through a PIX_LATENCY-deep shift register.
  - The output stage then registers on each edge: rgb <= blank_d ? 0 : pixel_in; hs <= hs_d; vs <= vs_d.
  - Pin latency from the counter value is PIX_LATENCY+1 clocks; pixel and sync are always coincident.
  - PIX_LATENCY=0 means no delay stages, only the output register.
- Colour split: pixel_in[11:8] -> r, [7:4] -> g, [3:0] -> b.
- pixel_in is ignored (pins forced 0) whenever the delayed blank is high.
- Reset mid-frame: all state returns to reset values at once. After release, timing restarts at (0,0) with a fresh frame_start_out pulse; no partial line is emitted.
- Out-of-range parameters: PIX_LATENCY > 7, or H_TOTAL/V_TOTAL not fitting 11/10 bits, fail an elaboration-time check.

Test Plan:
- Reset release, defaults -> edge 1: hcount=0, vcount=0, frame_start=1, frame_count=1. Edge 2: hcount=1, frame_start=0.
- Run to hcount=1343, vcount=5 -> next edge hcount=0, vcount=6. At (1343,805) -> next edge (0,0), frame_start=1, frame_count increments; at 65535 it wraps to 0.
- PIX_LATENCY=2 -> vga_hs_out falls 3 clocks after hcount_out becomes 1048 and stays low exactly 136 clocks. vga_vs_out goes low 3 clocks after (0,771) and stays low 6x1344 clocks.
- pixel_in held at 12'hB70 -> pins r=4'hB, g=4'h7, b=4'h0 during active area. Pins are 0 for 320 clocks per line starting 3 clocks after hcount=1024, and for lines 768..805. blank_out high exactly when hcount>=1024 or vcount>=768.
- Assert rst_n_in low at (500,300) between edges -> all outputs take reset values immediately. After release: first edge (0,0), frame_start=1, frame_count=1.
- PIX_LATENCY=0, pixel_in toggling 12'h971/12'h000 each clock -> pins follow with exactly 1-clock lag; vga_hs_out falls 1 clock after hcount=1048.
